alu_flag_reg: RTL
=================

# alu_flag_reg

Parametrised NZCV status unit for the ARMv4 datapath, the successor of the combinational flag generator. It derives N, Z, C and V from a WIDTH-bit ALU result according to the operation class. It holds them in a status register with split write enables, and evaluates the 4-bit ARM condition field against the stored flags. It also keeps a sticky overflow bit and a saturating overflow-event counter for debug. It sits between the ALU and the decode/conditional-execute logic.

## Interface
- WIDTH, 32, datapath width in bits (≥2)
- CNT_W, 8, width of overflow-event counter (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- aOp  in  WIDTH  ALU operand A
- bOp  in  WIDTH  ALU operand B (already shifted)
- result  in  WIDTH  ALU result
- cout  in  1  adder carry-out
- shCarry  in  1  shifter carry-out, used by logical ops
- multV  in  1  multiplier overflow
- aluControl  in  4  operation class: 0000 ADD, 0001 SUB, 0010 MUL, 0011–0111 logical/move; 1xxx reserved
- flagW  in  2  write enables: [1] updates N,Z; [0] updates C,V
- cond  in  4  ARM condition field of the current instruction
- clearQ  in  1  clears sticky Q and the counter
- condEx  out  1  condition passes on the stored flags (combinational)
- N, Z, C, V  out  1 each  stored flags
- Q  out  1  sticky overflow
- ovfCount  out  CNT_W  saturating count of V-setting writes

## Operation
- Next-flag computation, combinational:
  - nN = result[WIDTH-1]
  - nZ = (result == 0)
- ADD: nC = cout, nV = (aOp[MSB] == bOp[MSB]) & (result[MSB] != aOp[MSB]).
- SUB (A − B, cout = NOT borrow): nC = cout, nV = (aOp[MSB] != bOp[MSB]) & (result[MSB] != aOp[MSB]).
- MUL: nC = current C (unchanged), nV = multV.
- Logical/move: nC = shCarry, nV = current V (unchanged).
- Reserved opcodes: nC = C, nV = V. N/Z are still computed.
- Condition evaluation on the stored flags:
  - EQ Z, NE ~Z, CS C, CC ~C
  - MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 (NV) 0
- Write gating:
  - N,Z load when flagW[1] & condEx.
  - C,V load when flagW[0] & condEx.
  - Otherwise the flags hold.
- Overflow event = flagW[0] & condEx & nV.
  - On an event: Q ← 1, and ovfCount increments, saturating at 2^CNT_W−1.
- clearQ: Q ← 0 and ovfCount ← 0, unless an event occurs in the same cycle. In that case Q ← 1 and ovfCount ← 1 (set wins).
- Reset: N=Z=C=V=0, Q=0, ovfCount=0. With flags at 0, condEx immediately reflects them, e.g. cond=0001 (NE) gives 1.

## Timing
- The flag register has 1-cycle latency: values computed in cycle t are visible on N/Z/C/V/Q/ovfCount after the rising edge ending cycle t.
- condEx is combinational from cond and the stored flags. It never sees same-cycle nN..nV, so a flag-setting instruction's effect is seen by the next instruction.
- No handshake. Every cycle with a nonzero flagW is a write attempt.
- rst_n assertion mid-operation clears all state asynchronously. Deassertion is sampled at the next clk edge, and the first update occurs on the first edge with rst_n high.
- The counter does not wrap: at all-ones, further events leave it at all-ones and still set Q.

## Test plan
- Reset, then cond=0000 / 0001 / 1110 / 1111 → condEx = 0 / 1 / 1 / 0, and all outputs 0.
- WIDTH=32, ADD aOp=0x7FFFFFFF, bOp=1, result=0x80000000, cout=0, flagW=11, cond=1110 → next cycle N=1, Z=0, C=0, V=1, Q=1, ovfCount=1. Then cond=0110 → condEx=1.
- SUB aOp=5, bOp=5, result=0, cout=1, flagW=11 → Z=1, C=1, N=0, V=0. Then cond=1000 (HI) → 0, cond=1001 (LS) → 1.
- Gating:
  - Logical op, result=0, shCarry=1, flagW=10 → Z=1; C and V retain their prior values.
  - Same inputs with cond=0000 while Z=0 → no flag change.
- CNT_W=2, four consecutive V-setting writes → ovfCount = 1, 2, 3, 3. Then clearQ with an event in the same cycle → Q=1, ovfCount=1. Then clearQ alone → Q=0, ovfCount=0.
- Assert rst_n low between clk edges during a V-setting stream → all outputs 0 immediately, with no update at the next edge while rst_n is low.

Source files
------------

// File: rtl/alu_flag_reg.sv
// NZCV status register: derives next flags from the ALU result and operation class,
// gates writes on the stored-flag condition check, and tracks sticky/saturating overflow.
module alu_flag_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] aOp,
  input  logic [WIDTH-1:0] bOp,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic             shCarry,
  input  logic             multV,
  input  logic [3:0]       aluControl,
  input  logic [1:0]       flagW,
  input  logic [3:0]       cond,
  input  logic             clearQ,
  output logic             condEx,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             Q,
  output logic [CNT_W-1:0] ovfCount
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic n_q, z_q, c_q, v_q, q_q;
  logic n_d, z_d, c_d, v_d, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic nxt_n_s, nxt_z_s, nxt_c_s, nxt_v_s;
  logic wr_nz_s, wr_cv_s, ovf_evt_s;

  function automatic logic cond_pass(input logic [3:0] c, input logic n, input logic z,
                                     input logic cf, input logic v);
    logic p;
    case (c)
      4'b0000: p = z;
      4'b0001: p = ~z;
      4'b0010: p = cf;
      4'b0011: p = ~cf;
      4'b0100: p = n;
      4'b0101: p = ~n;
      4'b0110: p = v;
      4'b0111: p = ~v;
      4'b1000: p = cf & ~z;
      4'b1001: p = ~cf | z;
      4'b1010: p = (n == v);
      4'b1011: p = (n != v);
      4'b1100: p = ~z & (n == v);
      4'b1101: p = z | (n != v);
      4'b1110: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Candidate flags from the current ALU operation
  always_comb begin
    nxt_n_s = result[MSB];
    nxt_z_s = (result == {WIDTH{1'b0}});
    nxt_c_s = c_q;
    nxt_v_s = v_q;
    case (aluControl)
      4'b0000: begin
        nxt_c_s = cout;
        nxt_v_s = (aOp[MSB] == bOp[MSB]) & (result[MSB] != aOp[MSB]);
      end
      4'b0001: begin
        nxt_c_s = cout;
        nxt_v_s = (aOp[MSB] != bOp[MSB]) & (result[MSB] != aOp[MSB]);
      end
      4'b0010: begin
        nxt_c_s = c_q;
        nxt_v_s = multV;
      end
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        nxt_c_s = shCarry;
        nxt_v_s = v_q;
      end
      default: begin
        nxt_c_s = c_q;
        nxt_v_s = v_q;
      end
    endcase
  end

  assign condEx    = cond_pass(cond, n_q, z_q, c_q, v_q);
  assign wr_nz_s   = flagW[1] & condEx;
  assign wr_cv_s   = flagW[0] & condEx;
  assign ovf_evt_s = wr_cv_s & nxt_v_s;

  // Gated flag loads; an overflow event takes priority over clearQ
  always_comb begin
    n_d   = n_q;
    z_d   = z_q;
    c_d   = c_q;
    v_d   = v_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    if (wr_nz_s) begin
      n_d = nxt_n_s;
      z_d = nxt_z_s;
    end else begin
      n_d = n_q;
      z_d = z_q;
    end
    if (wr_cv_s) begin
      c_d = nxt_c_s;
      v_d = nxt_v_s;
    end else begin
      c_d = c_q;
      v_d = v_q;
    end
    if (ovf_evt_s) begin
      q_d = 1'b1;
      if (clearQ) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (clearQ) begin
      q_d   = 1'b0;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      q_d   = q_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      q_q   <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      n_q   <= n_d;
      z_q   <= z_d;
      c_q   <= c_d;
      v_q   <= v_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign N        = n_q;
  assign Z        = z_q;
  assign C        = c_q;
  assign V        = v_q;
  assign Q        = q_q;
  assign ovfCount = cnt_q;

endmodule
